cpu_commit_tracer: RTL and testbench

//  Synthesizable commit tracer that sits beside the single-cycle CPU and observes one retired instruction per clk_i.
//  For each instruction it pushes a record into an internal FIFO: cycle stamp, PC, register write enable, rd and write data.

---
 rtl/cpu_commit_tracer.sv | 148 ++++++++++++++
 tb/tb_cpu_commit_tracer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_commit_tracer.sv
// cpu_commit_tracer: observes one retired instruction per clock and queues a
// commit record (cycle stamp, PC, write enable, rd, data) in a small FIFO that
// drains over a valid/ready stream. Tracing stops on an all-zero instruction
// word (halt) or after MAX_CYCLES traced cycles (timeout).
// Optional feature macro: TRACE_FILTER_EN -- when defined, only instructions
// that really write a register (rd_we_i and rd_addr_i != 0) are recorded.
module cpu_commit_tracer #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 500
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      inst_i,
    input  logic             rd_we_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [XLEN-1:0]  rd_data_i,
    output logic             trc_valid_o,
    input  logic             trc_ready_i,
    output logic [CNT_W-1:0] trc_cycle_o,
    output logic [XLEN-1:0]  trc_pc_o,
    output logic             trc_we_o,
    output logic [4:0]       trc_rd_o,
    output logic [XLEN-1:0]  trc_data_o,
    output logic             halted_o,
    output logic             timeout_o,
    output logic             overflow_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] cycle;
        logic [XLEN-1:0]  pc;
        logic             we;
        logic [4:0]       rd;
        logic [XLEN-1:0]  data;
    } rec_t;

    state_t        state;
    rec_t          mem [DEPTH];
    rec_t          head;
    rec_t          new_rec;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic is_halt, rec_we, keep, push_req, push, pop, drop;
    logic empty, full, at_limit, cnt_max;

    assign is_halt  = (inst_i == 32'h0);
    assign rec_we   = rd_we_i & (rd_addr_i != 5'd0);
`ifdef TRACE_FILTER_EN
    assign keep     = rec_we;
`else
    assign keep     = 1'b1;
`endif
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = !empty && trc_ready_i;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push_req = (state == RUN) && !is_halt && keep;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign at_limit = (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1));
    assign cnt_max  = &cycle_cnt_o;

    assign new_rec = '{cycle: cycle_cnt_o, pc: pc_i, we: rec_we,
                       rd: rd_addr_i, data: rd_data_i};

    // Head record is forced to zero while empty so stale/unwritten slots never leak out.
    assign head        = mem[rd_ptr];
    assign trc_valid_o = !empty;
    assign trc_cycle_o = empty ? '0 : head.cycle;
    assign trc_pc_o    = empty ? '0 : head.pc;
    assign trc_we_o    = empty ? 1'b0 : head.we;
    assign trc_rd_o    = empty ? '0 : head.rd;
    assign trc_data_o  = empty ? '0 : head.data;

    // Record storage write port.
    // NOTE: the storage array has no reset; validity is tracked by count, so clearing it buys nothing.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= new_rec;
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Tracing FSM with registered status flags and cycle counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cycle_cnt_o <= '0;
            halted_o    <= 1'b0;
            timeout_o   <= 1'b0;
            overflow_o  <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            if (drop) overflow_o <= 1'b1;
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (is_halt) begin
                        // Halt takes priority over a coincident timeout.
                        halted_o <= 1'b1;
                        state    <= DRAIN;
                    end else begin
                        if (!cnt_max) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
                        if (at_limit) begin
                            timeout_o <= 1'b1;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (empty || (count == CW'(1) && pop)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_commit_tracer.sv
// Directed testbench for cpu_commit_tracer: table-driven commit sequence plus
// hand-written overflow, full-FIFO, timeout and reset sequences.
module tb_cpu_commit_tracer;

`ifdef TRACE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_to = 1'b0;
    logic [31:0] pc = '0, inst = '0, rd_data = '0;
    logic        rd_we = 1'b0, ready = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic        valid, twe, halted, timeout, overflow, done;
    logic [15:0] cyc, cnt;
    logic [31:0] tpc, tdata;
    logic [4:0]  trd;

    logic        valid_t, twe_t, halted_t, timeout_t, overflow_t, done_t;
    logic [15:0] cyc_t, cnt_t;
    logic [31:0] tpc_t, tdata_t;
    logic [4:0]  trd_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_commit_tracer dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .inst_i(inst), .rd_we_i(rd_we),
        .rd_addr_i(rd_addr), .rd_data_i(rd_data), .trc_valid_o(valid),
        .trc_ready_i(ready), .trc_cycle_o(cyc), .trc_pc_o(tpc), .trc_we_o(twe),
        .trc_rd_o(trd), .trc_data_o(tdata), .halted_o(halted), .timeout_o(timeout),
        .overflow_o(overflow), .done_o(done), .cycle_cnt_o(cnt)
    );

    cpu_commit_tracer #(.MAX_CYCLES(5)) dut_to (
        .clk_i(clk), .rst_i(rst_to), .pc_i(pc), .inst_i(inst), .rd_we_i(rd_we),
        .rd_addr_i(rd_addr), .rd_data_i(rd_data), .trc_valid_o(valid_t),
        .trc_ready_i(ready), .trc_cycle_o(cyc_t), .trc_pc_o(tpc_t), .trc_we_o(twe_t),
        .trc_rd_o(trd_t), .trc_data_o(tdata_t), .halted_o(halted_t), .timeout_o(timeout_t),
        .overflow_o(overflow_t), .done_o(done_t), .cycle_cnt_o(cnt_t)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] ins, input logic w,
                         input logic [4:0] r, input logic [31:0] d);
        pc = p; inst = ins; rd_we = w; rd_addr = r; rd_data = d;
    endtask

    // Generated instruction stream: index i -> pc 4*i, rd (i%31)+1, data A000_0000+i.
    task automatic drive_idx(input int i);
        drive(32'(i * 4), 32'h0000_0013 | (32'(i) << 20), 1'b1, 5'(i % 31 + 1),
              32'hA000_0000 + 32'(i));
    endtask

    task automatic check_rec(input string tag, input logic v, input logic [15:0] c,
                             input logic [31:0] p, input logic w, input logic [4:0] r,
                             input logic [31:0] d, input logic [15:0] ec, input logic [31:0] ep,
                             input logic ew, input logic [4:0] er, input logic [31:0] ed);
        check({tag, "_valid"}, 64'(v), 64'(1'b1));
        check({tag, "_cycle"}, 64'(c), 64'(ec));
        check({tag, "_pc"},    64'(p), 64'(ep));
        check({tag, "_we"},    64'(w), 64'(ew));
        check({tag, "_rd"},    64'(r), 64'(er));
        check({tag, "_data"},  64'(d), 64'(ed));
    endtask

    task automatic check_idx(input string tag, input int i);
        check_rec(tag, valid, cyc, tpc, twe, trd, tdata,
                  16'(i), 32'(i * 4), 1'b1, 5'(i % 31 + 1), 32'hA000_0000 + 32'(i));
    endtask

    task automatic check_idx_t(input string tag, input int i);
        check_rec(tag, valid_t, cyc_t, tpc_t, twe_t, trd_t, tdata_t,
                  16'(i), 32'(i * 4), 1'b1, 5'(i % 31 + 1), 32'hA000_0000 + 32'(i));
    endtask

    // Reset pulse on the main instance; returns at a negedge with the FSM in RUN.
    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic do_reset_to();
        rst_to = 1'b0;
        @(negedge clk);
        rst_to = 1'b1;
        step();
    endtask

    initial begin
        tbl[0] = '{pc: 32'h0, inst: 32'h0070_0293, we: 1'b1, rd: 5'd5, data: 32'd7, exp_we: 1'b1};
        tbl[1] = '{pc: 32'h4, inst: 32'h0090_0013, we: 1'b1, rd: 5'd0, data: 32'd9, exp_we: 1'b0};
        tbl[2] = '{pc: 32'h8, inst: 32'h0000_0013, we: 1'b0, rd: 5'd0, data: 32'd0, exp_we: 1'b0};

        // Test 1: reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_flags", 64'({halted, timeout, overflow, done}), 64'(0));
        check("rst_cnt", 64'(cnt), 64'(0));
        check("rst_head", 64'({cyc, tpc, twe, trd, tdata}), 64'(0));
        rst = 1'b1;
        step();
        check("run_cnt0", 64'(cnt), 64'(0));
        check("run_valid0", 64'(valid), 64'(0));

        // Test 2: table-driven commit sequence with ready held high.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic kept;
            kept = FILT ? tbl[i].exp_we : 1'b1;
            drive(tbl[i].pc, tbl[i].inst, tbl[i].we, tbl[i].rd, tbl[i].data);
            step();
            if (kept)
                check_rec($sformatf("t2_r%0d", i), valid, cyc, tpc, twe, trd, tdata,
                          16'(i), tbl[i].pc, tbl[i].exp_we, tbl[i].rd, tbl[i].data);
            else
                check($sformatf("t2_r%0d_valid", i), 64'(valid), 64'(0));
        end
        drive(32'hC, 32'h0, 1'b1, 5'd3, 32'h55);
        step();
        check("t2_halted", 64'(halted), 64'(1));
        check("t2_timeout", 64'(timeout), 64'(0));
        check("t2_cnt", 64'(cnt), 64'(3));
        check("t2_done_early", 64'(done), 64'(0));
        step();
        check("t2_done", 64'(done), 64'(1));
        drive_idx(9);
        step();
        check("t2_done_ignore", 64'({valid, cnt}), 64'({1'b0, 16'd3}));

        // Test 3: overflow with ready low, then in-order drain.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_idx(i);
            step();
            if (i == 15) check("t3_ovf_before", 64'(overflow), 64'(0));
            if (i == 16) check("t3_ovf_after", 64'(overflow), 64'(1));
            if (i == 5 || i == 19) check_idx($sformatf("t3_hold%0d", i), 0);
        end
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check("t3_halted", 64'(halted), 64'(1));
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_idx($sformatf("t3_d%0d", i), i);
            step();
        end
        check("t3_empty", 64'(valid), 64'(0));
        check("t3_done", 64'(done), 64'(1));

        // Test 5: full FIFO with a same-cycle push and pop.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_idx(i);
            step();
        end
        check("t5_ovf_full", 64'(overflow), 64'(0));
        ready = 1'b1;
        drive_idx(16);
        step();
        check("t5_ovf_pushpop", 64'(overflow), 64'(0));
        check_idx("t5_head1", 1);
        ready = 1'b0;
        drive_idx(17);
        step();
        check("t5_ovf_drop", 64'(overflow), 64'(1));
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check_idx($sformatf("t5_d%0d", i), i);
            step();
        end
        check("t5_done", 64'({valid, done}), 64'({1'b0, 1'b1}));

        // Test 4: timeout at MAX_CYCLES=5 on the second instance.
        rst = 1'b0;
        do_reset_to();
        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_idx(i);
            step();
            if (i == 3) check("t4_to_before", 64'(timeout_t), 64'(0));
            if (i == 4) begin
                check("t4_to", 64'(timeout_t), 64'(1));
                check("t4_halted", 64'(halted_t), 64'(0));
                check("t4_cnt", 64'(cnt_t), 64'(5));
            end
        end
        check("t4_cnt_frozen", 64'(cnt_t), 64'(5));
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_idx_t($sformatf("t4_d%0d", i), i);
            step();
        end
        check("t4_done", 64'({valid_t, done_t}), 64'({1'b0, 1'b1}));

        // Halt and timeout on the same edge: halt wins.
        do_reset_to();
        for (int i = 0; i < 4; i++) begin
            drive_idx(i);
            step();
        end
        drive(32'h10, 32'h0, 1'b1, 5'd1, 32'h1);
        step();
        check("hto_halted", 64'(halted_t), 64'(1));
        check("hto_timeout", 64'(timeout_t), 64'(0));
        check("hto_cnt", 64'(cnt_t), 64'(4));
        step();
        check("hto_done", 64'(done_t), 64'(1));
        rst_to = 1'b0;

        // Test 6: asynchronous reset in the middle of DRAIN.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_idx(i);
            step();
        end
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check("t6_drain", 64'({valid, done, halted}), 64'({1'b1, 1'b0, 1'b1}));
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", 64'(valid), 64'(0));
        check("t6_rst_flags", 64'({halted, done, cnt}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        step();
        check("t6_after", 64'({valid, done, cnt}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
